// File: rtl/undelay.sv
// undelay: echo-removal stage for the mixer synthesis chain.
//
// Undoes the single-tap 1:1 echo applied upstream,
// y[n] = ceil(x[n]/2) + floor(x[n-D]/2).
// It rebuilds the dry stream recursively with x[n] = 2*(y[n] - (x[n-D] >>> 1)).
// A D-deep circular history buffer holds the reconstructed samples.
//
// Parameters:
//   D  echo distance in accepted samples (2..4096), must match upstream
//   W  sample width, signed two's complement
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   on         1 = remove echo, 0 = pass-through (sampled on wren cycles)
//   in_data    echoed input sample
//   wren       in_data valid this cycle, no backpressure
//   out_data   reconstructed sample, 0 when out_valid is 0
//   out_valid  registered copy of wren (1 cycle latency)
//   out_clip   result was saturated this sample
//
// Configuration macro:
//   UNDELAY_SAT_EN  defined   -> result clamped to the W-bit range, out_clip live
//                   undefined -> result wraps to W bits, out_clip tied to 0
module undelay #(
  parameter int D = 1024,
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         on,
  input  logic [W-1:0] in_data,
  input  logic         wren,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_clip
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int FW = $clog2(D + 1);
  localparam logic [AW-1:0] WP_LAST  = AW'(D - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wp;
  logic [AW-1:0] wp_next;
  logic [AW-1:0] rd_addr;
  logic [FW-1:0] fill;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  h;
  logic [W-1:0]  h_half;
  logic          accept;
  logic [W-1:0]  x_echo;
  logic          clip_echo;
  logic [W-1:0]  x_sel;
  logic          clip_sel;

  // A wren that coincides with reset is dropped.
  assign accept  = wren & ~reset;
  assign wp_next = (wp == WP_LAST) ? '0 : wp + 1'b1;

  // Read address targets the slot that wp will point at after this edge.
  // So rd_data already holds mem[wp] on the next accepted sample.
  // D >= 2 keeps this slot apart from the one being written now.
  assign rd_addr = reset ? '0 : (accept ? wp_next : wp);

  // History only counts once D samples have been stored since reset.
  // Stale buffer contents are therefore never seen.
  assign h      = (fill == FILL_MAX) ? rd_data : '0;
  assign h_half = {h[W-1], h[W-1:1]};

`ifdef UNDELAY_SAT_EN
  logic signed [W:0]   c;
  logic signed [W+1:0] r;

  assign c = $signed({in_data[W-1], in_data}) - $signed({h_half[W-1], h_half});
  assign r = {c, 1'b0};

  // r fits in W bits only if its top three bits agree (r is always even).
  always_comb begin
    x_echo    = r[W-1:0];
    clip_echo = 1'b0;
    if (!((r[W+1:W-1] == 3'b000) || (r[W+1:W-1] == 3'b111))) begin
      clip_echo = 1'b1;
      x_echo    = r[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  // Without saturation only the low W bits of 2*(in - h/2) survive.
  assign x_echo    = (in_data - h_half) << 1;
  assign clip_echo = 1'b0;
`endif

  assign x_sel    = on ? x_echo : in_data;
  assign clip_sel = on & clip_echo;

  // History buffer: no reset, so it can map onto block RAM.
  // Read and write are both synchronous.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wp] <= x_sel;
    end
    rd_data <= mem[rd_addr];
  end

  // Write pointer wraps at D; the fill counter saturates at D.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp   <= '0;
      fill <= '0;
    end else if (wren) begin
      wp <= wp_next;
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_clip  <= 1'b0;
    end else begin
      out_valid <= wren;
      out_data  <= wren ? x_sel : '0;
      out_clip  <= wren & clip_sel;
    end
  end

endmodule

// File: tb/tb_undelay.sv
// tb_undelay: self-checking bench for undelay with D=4, W=24.
// Expected outputs are queued when a sample is driven.
// They are popped and compared whenever out_valid is seen.
module tb_undelay;

  localparam int D = 4;
  localparam int W = 24;

`ifdef UNDELAY_SAT_EN
  localparam logic [W-1:0] SAT_P  = 24'h7FFFFF;
  localparam logic         SAT_PC = 1'b1;
  localparam logic [W-1:0] SAT_N  = 24'h800000;
  localparam logic         SAT_NC = 1'b1;
`else
  localparam logic [W-1:0] SAT_P  = 24'hFFFFFE;
  localparam logic         SAT_PC = 1'b0;
  localparam logic [W-1:0] SAT_N  = 24'h000000;
  localparam logic         SAT_NC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         on;
  logic [W-1:0] in_data;
  logic         wren;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_clip;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic         rst;
    logic         on;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         clip;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   xh[$];

  undelay #(.D(D), .W(W)) dut (
    .clk(clk),
    .reset(reset),
    .on(on),
    .in_data(in_data),
    .wren(wren),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_clip(out_clip)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic o, logic [W-1:0] din, logic [W-1:0] dout, logic clip);
    vec_t v;
    v.rst  = rst;
    v.on   = o;
    v.din  = din;
    v.dout = dout;
    v.clip = clip;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one accepted sample for one cycle and queue its expected result.
  task automatic apply_stimulus(input logic o, input logic [W-1:0] din, input logic [W-1:0] dout, input logic clip);
    exp_t e;
    e.d     = dout;
    e.c     = clip;
    sb.push_back(e);
    on      = o;
    in_data = din;
    wren    = 1'b1;
    @(posedge clk);
    #1;
    wren    = 1'b0;
    in_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle reset, optionally with a coincident wren that must be dropped.
  task automatic do_reset(input logic wr, input logic [W-1:0] d);
    @(negedge clk);
    #1;
    check_output("scoreboard_empty_before_reset", W'(sb.size()), '0);
    sb.delete();
    reset   = 1'b1;
    wren    = wr;
    on      = 1'b1;
    in_data = d;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    wren    = 1'b0;
    in_data = '0;
  endtask

  // Monitor: compare every valid output against the scoreboard.
  // Idle cycles must show zero data and no clip.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %h with nothing expected at %0t", out_data, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("stream_data", out_data, e.d);
          check_output("stream_clip", W'(out_clip), W'(e.c));
        end
      end else begin
        check_output("idle_data", out_data, '0);
        check_output("idle_clip", W'(out_clip), '0);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    on      = 1'b0;
    in_data = '0;
    wren    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("reset_valid", W'(out_valid), '0);
    check_output("reset_data", out_data, '0);
    check_output("reset_clip", W'(out_clip), '0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Impulse: the echo of 500 is cancelled D samples later.
    vecs.push_back(mk(1, 1, 24'd500, 24'd1000, 0));
    vecs.push_back(mk(0, 1, 24'd0,   24'd0,    0));
    vecs.push_back(mk(0, 1, 24'd0,   24'd0,    0));
    vecs.push_back(mk(0, 1, 24'd0,   24'd0,    0));
    vecs.push_back(mk(0, 1, 24'd500, 24'd0,    0));
    vecs.push_back(mk(0, 1, 24'd0,   24'd0,    0));
    vecs.push_back(mk(0, 1, 24'd0,   24'd0,    0));
    vecs.push_back(mk(0, 1, 24'd0,   24'd0,    0));
    // Pass-through is recorded, then on=1 cancels it exactly at the fill boundary.
    vecs.push_back(mk(1, 0, 24'h123456, 24'h123456, 0));
    vecs.push_back(mk(0, 1, 24'h000000, 24'h000000, 0));
    vecs.push_back(mk(0, 1, 24'h000000, 24'h000000, 0));
    vecs.push_back(mk(0, 1, 24'h000000, 24'h000000, 0));
    vecs.push_back(mk(0, 1, 24'h091A2B, 24'h000000, 0));
    // Saturation at both ends of the range.
    vecs.push_back(mk(1, 1, 24'h7FFFFF, SAT_P, SAT_PC));
    vecs.push_back(mk(0, 1, 24'h800000, SAT_N, SAT_NC));
    vecs.push_back(mk(0, 1, 24'h000000, 24'h000000, 0));
    // Non-zero stale history must stay hidden after reset.
    vecs.push_back(mk(1, 0, 24'h000111, 24'h000111, 0));
    vecs.push_back(mk(0, 0, 24'h000222, 24'h000222, 0));
    vecs.push_back(mk(0, 0, 24'h000333, 24'h000333, 0));
    vecs.push_back(mk(0, 0, 24'h000444, 24'h000444, 0));
    vecs.push_back(mk(1, 1, 24'h000000, 24'h000000, 0));
    vecs.push_back(mk(0, 1, 24'h000000, 24'h000000, 0));
    vecs.push_back(mk(0, 1, 24'h000000, 24'h000000, 0));
    vecs.push_back(mk(0, 1, 24'h000000, 24'h000000, 0));
    vecs.push_back(mk(0, 1, 24'h000200, 24'h000400, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset(1'b0, '0);
      apply_stimulus(vecs[i].on, vecs[i].din, vecs[i].dout, vecs[i].clip);
    end

    // Reset mid-stream with a coincident wren.
    $display("[TB] reset mid-stream sequence");
    do_reset(1'b0, '0);
    apply_stimulus(1, 24'd500, 24'd1000, 0);
    apply_stimulus(1, 24'd0,   24'd0,    0);
    apply_stimulus(1, 24'd0,   24'd0,    0);
    apply_stimulus(1, 24'd0,   24'd0,    0);
    apply_stimulus(1, 24'd500, 24'd0,    0);
    apply_stimulus(1, 24'd0,   24'd0,    0);
    do_reset(1'b1, 24'd500);
    @(negedge clk);
    check_output("post_reset_valid", W'(out_valid), '0);
    check_output("post_reset_data", out_data, '0);
    @(posedge clk);
    #1;
    apply_stimulus(1, 24'd500, 24'd1000, 0);
    apply_stimulus(1, 24'd0,   24'd0,    0);
    apply_stimulus(1, 24'd0,   24'd0,    0);
    apply_stimulus(1, 24'd0,   24'd0,    0);
    apply_stimulus(1, 24'd500, 24'd0,    0);

    // Round trip through an upstream echo model, with random wren gaps.
    $display("[TB] round trip sequence");
    do_reset(1'b0, '0);
    for (int n = 0; n < 24; n++) begin
      int xi;
      int yi;
      xi = int'($urandom_range(0, 8388607)) - 4194304;
      xi = xi & ~1;
      xh.push_back(xi);
      yi = xi / 2 + ((n >= D) ? xh[n-D] / 2 : 0);
      apply_stimulus(1, W'(yi), W'(xi), 0);
      idle(int'($urandom_range(0, 5)));
    end

    idle(3);
    check_output("scoreboard_drain", W'(sb.size()), '0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
